e_lock_init: RTL and testbench

Keypad-driven electronic door lock controller with intrusion alarm. Decodes a 4×3 matrix keypad and a door-contact input, tracks an arm/disarm state machine with a fixed 4-digit passcode, and drives five status lights plus a key-accepted strobe. It sits between the board-level keypad/door I/O and the indicator LEDs/buzzer.

---
 rtl/e_lock_init.sv | 193 +++++++++++++++++++
 tb/tb_e_lock_init.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_lock_init.sv
// e_lock_init: 4x3 keypad door lock with arm/disarm state machine and intrusion alarm.
// Keypad and door inputs pass through one register stage before any decoding.
module e_lock_init #(
  parameter logic [15:0] CODE      = 16'h1155,
  parameter int unsigned MAX_FAILS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       door,
  input  logic [3:0] row,
  input  logic [2:0] col,
  output logic [4:0] lights,
  output logic       key_signal
);

  localparam int unsigned FAIL_W = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ALARM    = 2'd2
  } state_t;

  // input stage; door is stored as "open" so the reset value means closed
  logic              r_door_open_s1;
  logic [3:0]        r_row_s1;
  logic [2:0]        r_col_s1;

  state_t            r_state;
  logic [15:0]       r_buf;
  logic [1:0]        r_cnt;
  logic [FAIL_W-1:0] r_fails;
  logic              r_opened;
  logic              r_latch;
  logic              r_key_signal;
  logic [4:0]        r_lights;

  state_t            w_state_next;
  logic [15:0]       w_buf_next;
  logic [1:0]        w_cnt_next;
  logic [FAIL_W-1:0] w_fails_next;
  logic [FAIL_W-1:0] w_fails_inc;
  logic              w_opened_next;
  logic [4:0]        w_lights_next;

  logic              w_row_onehot;
  logic              w_col_onehot;
  logic              w_key_valid;
  logic              w_key_idle;
  logic              w_press;
  logic [1:0]        w_row_idx;
  logic [1:0]        w_col_idx;
  logic              w_is_star;
  logic              w_is_hash;
  logic              w_is_digit;
  logic [3:0]        w_digit;
  logic [15:0]       w_entry;
  logic              w_code_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_door_open_s1 <= 1'b0;
      r_row_s1       <= '0;
      r_col_s1       <= '0;
    end else begin
      r_door_open_s1 <= ~door;
      r_row_s1       <= row;
      r_col_s1       <= col;
    end
  end

  assign w_row_onehot = (r_row_s1 != 4'd0) && ((r_row_s1 & (r_row_s1 - 4'd1)) == 4'd0);
  assign w_col_onehot = (r_col_s1 != 3'd0) && ((r_col_s1 & (r_col_s1 - 3'd1)) == 3'd0);
  assign w_key_valid  = w_row_onehot && w_col_onehot;
  assign w_key_idle   = (r_row_s1 == 4'd0) && (r_col_s1 == 3'd0);
  assign w_press      = w_key_valid && !r_latch;

  // row 0 = top (1/2/3), column 0 = left; only meaningful when w_key_valid
  always_comb begin
    w_row_idx = 2'd3;
    w_col_idx = 2'd2;
    case (r_row_s1)
      4'b1000: w_row_idx = 2'd0;
      4'b0100: w_row_idx = 2'd1;
      4'b0010: w_row_idx = 2'd2;
      default: w_row_idx = 2'd3;
    endcase
    case (r_col_s1)
      3'b100:  w_col_idx = 2'd0;
      3'b010:  w_col_idx = 2'd1;
      default: w_col_idx = 2'd2;
    endcase
  end

  assign w_is_star  = (w_row_idx == 2'd3) && (w_col_idx == 2'd0);
  assign w_is_hash  = (w_row_idx == 2'd3) && (w_col_idx == 2'd2);
  assign w_is_digit = !w_is_star && !w_is_hash;
  assign w_digit    = (w_row_idx == 2'd3) ? 4'd0
                    : (4'(w_row_idx) * 4'd3) + 4'(w_col_idx) + 4'd1;
  assign w_entry     = {r_buf[11:0], w_digit};
  assign w_code_ok   = (w_entry == CODE);
  assign w_fails_inc = r_fails + FAIL_W'(1);

  always_comb begin
    w_state_next  = r_state;
    w_buf_next    = r_buf;
    w_cnt_next    = r_cnt;
    w_fails_next  = r_fails;
    w_opened_next = r_opened;
    unique case (r_state)
      ST_DISARMED: begin
        w_buf_next = '0;
        w_cnt_next = '0;
        if (r_door_open_s1) begin
          w_opened_next = 1'b1;
        end else if (r_opened || (w_press && w_is_hash)) begin
          w_state_next  = ST_ARMED;
          w_fails_next  = '0;
          w_opened_next = 1'b0;
        end
      end
      ST_ARMED, ST_ALARM: begin
        // an open door while armed outranks a key decoded in the same cycle
        if ((r_state == ST_ARMED) && r_door_open_s1) begin
          w_state_next = ST_ALARM;
          w_buf_next   = '0;
          w_cnt_next   = '0;
        end else if (w_press && w_is_star) begin
          w_buf_next = '0;
          w_cnt_next = '0;
        end else if (w_press && w_is_digit) begin
          if (r_cnt == 2'd3) begin
            w_buf_next = '0;
            w_cnt_next = '0;
            if (w_code_ok) begin
              w_state_next  = ST_DISARMED;
              w_fails_next  = '0;
              w_opened_next = 1'b0;
            end else if (r_state == ST_ARMED) begin
              w_fails_next = w_fails_inc;
              if (w_fails_inc >= FAIL_W'(MAX_FAILS)) begin
                w_state_next = ST_ALARM;
              end
            end
          end else begin
            w_buf_next = w_entry;
            w_cnt_next = r_cnt + 2'd1;
          end
        end
      end
      default: begin
        w_state_next = ST_DISARMED;
      end
    endcase
  end

  assign w_lights_next = {(w_state_next == ST_ARMED) && (w_fails_next != '0),
                          r_door_open_s1,
                          w_state_next == ST_ALARM,
                          w_state_next == ST_ARMED,
                          w_state_next == ST_DISARMED};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_DISARMED;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_fails      <= '0;
      r_opened     <= 1'b0;
      r_latch      <= 1'b0;
      r_key_signal <= 1'b0;
      r_lights     <= 5'b00001;
    end else begin
      r_state      <= w_state_next;
      r_buf        <= w_buf_next;
      r_cnt        <= w_cnt_next;
      r_fails      <= w_fails_next;
      r_opened     <= w_opened_next;
      r_key_signal <= w_press;
      r_lights     <= w_lights_next;
      // only a fully idle keypad re-enables decoding; invalid chords keep the latch
      if (w_press) begin
        r_latch <= 1'b1;
      end else if (w_key_idle) begin
        r_latch <= 1'b0;
      end
    end
  end

  assign lights     = r_lights;
  assign key_signal = r_key_signal;

endmodule

// File: tb/tb_e_lock_init.sv
// Testbench for e_lock_init: directed scenarios plus randomized key/door traffic
// checked cycle by cycle against a keypad-level behavioural model.
module tb_e_lock_init;

  localparam logic [15:0] CODE      = 16'h1155;
  localparam int          MAX_FAILS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       door;
  logic [3:0] row;
  logic [2:0] col;
  logic [4:0] lights;
  logic       key_signal;

  e_lock_init #(.CODE(CODE), .MAX_FAILS(MAX_FAILS)) dut (
    .clk(clk), .rst(rst), .door(door), .row(row), .col(col),
    .lights(lights), .key_signal(key_signal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 = disarmed, 1 = armed, 2 = alarm
  int         m_state;
  int         m_fails;
  bit         m_latch;
  bit         m_opened;
  int         m_entry[$];
  bit         m_s1_dopen;
  logic [3:0] m_s1_row;
  logic [2:0] m_s1_col;
  logic [4:0] m_lights;
  bit         m_key;

  string keymap = "123456789*0#";
  string good   = "1155";
  string bad    = "1115";
  bit    door_lvl = 1'b1;
  int    dut_pulses = 0;
  int    mdl_pulses = 0;
  int    div_cycles = 0;

  task automatic take_key(input byte ch);
    int v;
    if (ch == "*") begin
      m_entry.delete();
    end else if (ch != "#") begin
      m_entry.push_back(int'(ch) - 48);
      if (m_entry.size() == 4) begin
        v = m_entry[0] * 4096 + m_entry[1] * 256 + m_entry[2] * 16 + m_entry[3];
        m_entry.delete();
        if (v == int'(CODE)) begin
          m_state = 0; m_fails = 0; m_opened = 1'b0;
        end else if (m_state == 1) begin
          m_fails++;
          if (m_fails >= MAX_FAILS) m_state = 2;
        end
      end
    end
  endtask

  task automatic model_edge(input bit r, input bit d, input logic [3:0] rw, input logic [2:0] cl);
    bit  valid, press;
    int  rp, cp;
    byte ch;
    if (r) begin
      m_state = 0; m_fails = 0; m_latch = 1'b0; m_opened = 1'b0; m_entry.delete();
      m_s1_dopen = 1'b0; m_s1_row = '0; m_s1_col = '0;
      m_lights = 5'b00001; m_key = 1'b0;
      return;
    end
    valid = ($countones(m_s1_row) == 1) && ($countones(m_s1_col) == 1);
    press = valid && !m_latch;
    if (press) m_latch = 1'b1;
    else if (m_s1_row == 4'd0 && m_s1_col == 3'd0) m_latch = 1'b0;
    ch = " ";
    if (press) begin
      rp = 0; cp = 0;
      for (int i = 0; i < 4; i++) if (m_s1_row[3-i]) rp = i;
      for (int j = 0; j < 3; j++) if (m_s1_col[2-j]) cp = j;
      ch = keymap[rp*3+cp];
    end
    case (m_state)
      0: begin
        if (m_s1_dopen) m_opened = 1'b1;
        else if (m_opened || ch == "#") begin
          m_state = 1; m_fails = 0; m_opened = 1'b0; m_entry.delete();
        end
      end
      1: begin
        if (m_s1_dopen) begin m_state = 2; m_entry.delete(); end
        else if (press) take_key(ch);
      end
      default: if (press) take_key(ch);
    endcase
    m_lights = {m_state == 1 && m_fails != 0, m_s1_dopen, m_state == 2, m_state == 1, m_state == 0};
    m_key = press;
    m_s1_dopen = !d; m_s1_row = rw; m_s1_col = cl;
  endtask

  // one clock: drive, advance model at the edge, observe 1 time unit later
  task automatic step(input bit r, input bit d, input logic [3:0] rw, input logic [2:0] cl);
    rst = r; door = d; row = rw; col = cl;
    @(posedge clk);
    model_edge(r, d, rw, cl);
    #1;
    if ({lights, key_signal} !== {m_lights, m_key}) div_cycles++;
    if (key_signal === 1'b1) dut_pulses++;
    if (m_key) mdl_pulses++;
  endtask

  task automatic key_rc(input byte ch, output logic [3:0] rw, output logic [2:0] cl);
    rw = '0; cl = '0;
    for (int i = 0; i < 12; i++)
      if (keymap[i] == ch) begin rw = 4'b1000 >> (i / 3); cl = 3'b100 >> (i % 3); end
  endtask

  task automatic press(input byte ch, input int hold, input int rel);
    logic [3:0] rw;
    logic [2:0] cl;
    key_rc(ch, rw, cl);
    repeat (hold) step(1'b0, door_lvl, rw, cl);
    repeat (rel) step(1'b0, door_lvl, 4'd0, 3'd0);
  endtask

  task automatic enter(input string s);
    for (int i = 0; i < s.len(); i++) press(s[i], 1, 1);
  endtask

  task automatic test_reset;
    int p0;
    step(1'b1, 1'b1, 4'd0, 3'd0);
    step(1'b1, 1'b1, 4'd0, 3'd0);
    n_vec++;
    if (lights !== 5'b00001 || key_signal !== 1'b0) begin
      n_err++; $display("FAIL reset: lights=%b key=%b expected 00001/0", lights, key_signal);
    end
    step(1'b0, 1'b1, 4'd0, 3'd0);
    p0 = dut_pulses;
    press("#", 1, 1);
    n_vec++;
    if (dut_pulses - p0 != 1 || lights !== 5'b00010) begin
      n_err++; $display("FAIL arm_hash: pulses=%0d lights=%b expected 1/00010", dut_pulses - p0, lights);
    end
  endtask

  task automatic test_disarm_rearm;
    int p0;
    p0 = dut_pulses;
    enter(good);
    n_vec++;
    if (dut_pulses - p0 != 4 || lights !== 5'b00001) begin
      n_err++; $display("FAIL disarm: pulses=%0d lights=%b expected 4/00001", dut_pulses - p0, lights);
    end
    door_lvl = 1'b0;
    repeat (3) step(1'b0, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (lights !== 5'b01001) begin
      n_err++; $display("FAIL door_open_disarmed: lights=%b expected 01001", lights);
    end
    door_lvl = 1'b1;
    repeat (3) step(1'b0, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (lights !== 5'b00010) begin
      n_err++; $display("FAIL auto_rearm: lights=%b expected 00010", lights);
    end
  endtask

  task automatic test_wrong_codes;
    enter(bad);
    n_vec++;
    if (lights !== 5'b10010) begin
      n_err++; $display("FAIL first_wrong: lights=%b expected 10010", lights);
    end
    enter(bad);
    n_vec++;
    if (lights !== 5'b00100) begin
      n_err++; $display("FAIL alarm_on_fails: lights=%b expected 00100", lights);
    end
    press("#", 1, 1);
    n_vec++;
    if (lights !== 5'b00100) begin
      n_err++; $display("FAIL alarm_hash_ignored: lights=%b expected 00100", lights);
    end
    enter(good);
    n_vec++;
    if (lights !== 5'b00001) begin
      n_err++; $display("FAIL alarm_clear: lights=%b expected 00001", lights);
    end
    press("#", 1, 1);
  endtask

  task automatic test_hold_invalid;
    int p0;
    p0 = dut_pulses;
    press("1", 50, 1);
    n_vec++;
    if (dut_pulses - p0 != 1) begin
      n_err++; $display("FAIL hold_key: pulses=%0d expected 1", dut_pulses - p0);
    end
    p0 = dut_pulses;
    repeat (3) step(1'b0, door_lvl, 4'b1100, 3'b100);
    step(1'b0, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (dut_pulses - p0 != 0 || lights !== 5'b00010) begin
      n_err++; $display("FAIL invalid_key: pulses=%0d lights=%b expected 0/00010", dut_pulses - p0, lights);
    end
    // key 2, invalid chord, key 3 with no idle gap: one event only
    p0 = dut_pulses;
    repeat (3) step(1'b0, door_lvl, 4'b1000, 3'b010);
    repeat (2) step(1'b0, door_lvl, 4'b1100, 3'b100);
    repeat (2) step(1'b0, door_lvl, 4'b1000, 3'b001);
    step(1'b0, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (dut_pulses - p0 != 1) begin
      n_err++; $display("FAIL invalid_not_release: pulses=%0d expected 1", dut_pulses - p0);
    end
    press("*", 1, 1);
    enter(good);
    n_vec++;
    if (lights !== 5'b00001) begin
      n_err++; $display("FAIL star_clear: lights=%b expected 00001", lights);
    end
    press("#", 1, 1);
  endtask

  task automatic test_simultaneous;
    int p0;
    logic [3:0] rw;
    logic [2:0] cl;
    key_rc("1", rw, cl);
    p0 = dut_pulses;
    door_lvl = 1'b0;
    step(1'b0, door_lvl, rw, cl);
    repeat (2) step(1'b0, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (dut_pulses - p0 != 1 || lights !== 5'b01100) begin
      n_err++; $display("FAIL door_and_key: pulses=%0d lights=%b expected 1/01100", dut_pulses - p0, lights);
    end
    door_lvl = 1'b1;
    repeat (2) step(1'b0, door_lvl, 4'd0, 3'd0);
    enter(good);
    press("#", 1, 1);
  endtask

  task automatic test_door_alarm;
    door_lvl = 1'b0;
    repeat (2) step(1'b0, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (lights !== 5'b01100) begin
      n_err++; $display("FAIL door_alarm: lights=%b expected 01100", lights);
    end
    step(1'b1, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (lights !== 5'b00001 || key_signal !== 1'b0) begin
      n_err++; $display("FAIL rst_in_alarm: lights=%b key=%b expected 00001/0", lights, key_signal);
    end
    repeat (2) step(1'b0, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (lights !== 5'b01001) begin
      n_err++; $display("FAIL door_after_rst: lights=%b expected 01001", lights);
    end
    door_lvl = 1'b1;
    repeat (3) step(1'b0, door_lvl, 4'd0, 3'd0);
    n_vec++;
    if (lights !== 5'b00010) begin
      n_err++; $display("FAIL rearm_after_rst: lights=%b expected 00010", lights);
    end
  endtask

  task automatic test_disarmed_digits;
    int p0;
    enter(good);
    p0 = dut_pulses;
    enter("1111");
    n_vec++;
    if (dut_pulses - p0 != 4 || lights !== 5'b00001 || lights[4] !== 1'b0) begin
      n_err++; $display("FAIL disarmed_digits: pulses=%0d lights=%b expected 4/00001", dut_pulses - p0, lights);
    end
  endtask

  task automatic test_random;
    int  k;
    byte ch;
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 19);
      if (k == 0) begin
        door_lvl = !door_lvl;
        repeat ($urandom_range(1, 3)) step(1'b0, door_lvl, 4'd0, 3'd0);
      end else if (k == 1) begin
        repeat (2) step(1'b0, door_lvl, 4'($urandom_range(1, 15)), 3'($urandom_range(1, 7)));
        step(1'b0, door_lvl, 4'd0, 3'd0);
      end else if (k == 2) begin
        enter(good);
      end else if (k == 3) begin
        ch = ($urandom_range(0, 1) == 0) ? 8'd49 : 8'd53;
        press(ch, $urandom_range(1, 3), $urandom_range(1, 2));
      end else begin
        ch = keymap[$urandom_range(0, 11)];
        press(ch, $urandom_range(1, 4), $urandom_range(1, 3));
      end
      n_vec++;
      if (lights !== m_lights || key_signal !== m_key) begin
        n_err++; $display("FAIL random_%0d: lights=%b key=%b expected %b/%b", it, lights, key_signal, m_lights, m_key);
      end
    end
    n_vec++;
    if (div_cycles != 0 || dut_pulses != mdl_pulses) begin
      n_err++; $display("FAIL cycle_trace: diverging_cycles=%0d pulses=%0d expected 0/%0d", div_cycles, dut_pulses, mdl_pulses);
    end
  endtask

  initial begin
    rst = 1'b1; door = 1'b1; row = '0; col = '0;
    test_reset();
    test_disarm_rearm();
    test_wrong_codes();
    test_hold_invalid();
    test_simultaneous();
    test_door_alarm();
    test_disarmed_digits();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
